// File: rtl/cache_loader.sv
// cache_loader
//   Boot-time initiator for the core's cache-write port. Parses a byte stream
//   of records from the boot link:
//     CMD_WRITE a0 a1 a2 a3 d0 d1 d2 d3  -> one cache write (little-endian)
//     CMD_DONE                           -> one load-complete strobe
//   After CMD_DONE the block discards all further traffic until reset.
//
// Ports
//   ip_clk, ip_rst (async, active-low)
//   ip_byte_data/ip_byte_valid/op_byte_ready : inbound byte stream
//   ip_hold                                  : core not ready, delays the write
//   op_wr_cache_data/addr/en/done_ctrl       : core cache-write interface
//   op_busy, op_error, op_word_count         : status
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for a command byte
// S_ADDR     | collecting the 4 address bytes
// S_DATA     | collecting the 4 data bytes
// S_WRITE    | record complete; check alignment, wait out ip_hold
// S_STROBE   | write strobe is high this cycle
// S_DONE     | issuing the load-complete strobe
// S_FINISHED | load finished; bytes are swallowed until reset
module cache_loader #(
   parameter logic [7:0] CMD_WRITE   = 8'hA5,
   parameter logic [7:0] CMD_DONE    = 8'h5A,
   parameter int         COUNT_WIDTH = 16
) (
   input  logic                   ip_clk,
   input  logic                   ip_rst,
   input  logic [7:0]             ip_byte_data,
   input  logic                   ip_byte_valid,
   output logic                   op_byte_ready,
   input  logic                   ip_hold,
   output logic [31:0]            op_wr_cache_data,
   output logic [31:0]            op_wr_cache_addr,
   output logic                   op_wr_cache_en,
   output logic                   op_wr_cache_done_ctrl,
   output logic                   op_busy,
   output logic                   op_error,
   output logic [COUNT_WIDTH-1:0] op_word_count
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ADDR     = 3'd1;
   localparam logic [2:0] S_DATA     = 3'd2;
   localparam logic [2:0] S_WRITE    = 3'd3;
   localparam logic [2:0] S_STROBE   = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;
   localparam logic [2:0] S_FINISHED = 3'd6;

   logic [2:0]             state_q, state_d;
   logic [1:0]             idx_q, idx_d;
   logic [31:0]            addr_q, addr_d;
   logic [31:0]            data_q, data_d;
   logic                   en_q, en_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   byte_ready;
   logic                   accept;

   // Ready is decoded from state only, so there is no path from ip_byte_valid.
   assign byte_ready = (state_q == S_IDLE) || (state_q == S_ADDR) ||
                       (state_q == S_DATA) || (state_q == S_FINISHED);
   assign accept     = ip_byte_valid && byte_ready;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      data_d  = data_q;
      en_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (ip_byte_data == CMD_WRITE) begin
                  state_d = S_ADDR;
                  idx_d   = 2'd0;
               end else if (ip_byte_data == CMD_DONE) begin
                  state_d = S_DONE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_ADDR: begin
            if (accept) begin
               addr_d[{idx_q, 3'b000} +: 8] = ip_byte_data;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               data_d[{idx_q, 3'b000} +: 8] = ip_byte_data;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (addr_q[1:0] != 2'b00) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (!ip_hold) begin
               en_d    = 1'b1;
               state_d = S_STROBE;
               if (cnt_q != {COUNT_WIDTH{1'b1}}) cnt_d = cnt_q + COUNT_WIDTH'(1);
            end
         end
         S_STROBE:   state_d = S_IDLE;
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_FINISHED;
         end
         S_FINISHED: state_d = S_FINISHED;
         default:    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ip_clk or negedge ip_rst) begin
      if (!ip_rst) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         addr_q  <= 32'd0;
         data_q  <= 32'd0;
         en_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         en_q    <= en_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign op_byte_ready         = byte_ready;
   assign op_wr_cache_addr      = addr_q;
   assign op_wr_cache_data      = data_q;
   assign op_wr_cache_en        = en_q;
   assign op_wr_cache_done_ctrl = done_q;
   assign op_error              = err_q;
   assign op_word_count         = cnt_q;
   assign op_busy               = (state_q != S_IDLE) && (state_q != S_FINISHED);

endmodule

// File: tb/tb_cache_loader.sv
// tb_cache_loader
//   Drives records into cache_loader and checks strobes, timing and status
//   against a queue-based record model.
module tb_cache_loader;

   logic        ip_clk = 1'b0;
   logic        ip_rst = 1'b0;
   logic [7:0]  ip_byte_data = 8'd0;
   logic        ip_byte_valid = 1'b0;
   logic        op_byte_ready;
   logic        ip_hold = 1'b0;
   logic [31:0] op_wr_cache_data;
   logic [31:0] op_wr_cache_addr;
   logic        op_wr_cache_en;
   logic        op_wr_cache_done_ctrl;
   logic        op_busy;
   logic        op_error;
   logic [15:0] op_word_count;

   cache_loader dut (
      .ip_clk                (ip_clk),
      .ip_rst                (ip_rst),
      .ip_byte_data          (ip_byte_data),
      .ip_byte_valid         (ip_byte_valid),
      .op_byte_ready         (op_byte_ready),
      .ip_hold               (ip_hold),
      .op_wr_cache_data      (op_wr_cache_data),
      .op_wr_cache_addr      (op_wr_cache_addr),
      .op_wr_cache_en        (op_wr_cache_en),
      .op_wr_cache_done_ctrl (op_wr_cache_done_ctrl),
      .op_busy               (op_busy),
      .op_error              (op_error),
      .op_word_count         (op_word_count)
   );

   always #5 ip_clk = ~ip_clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];
   int          exp_writes = 0;
   int          exp_cnt = 0;
   logic        exp_err = 1'b0;
   int          en_cnt = 0;
   int          done_cnt = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest expected record.
   always @(negedge ip_clk) begin
      if (ip_rst) begin
         if (op_wr_cache_en) begin
            en_cnt++;
            if (exp_q.size() > 0) begin
               logic [63:0] e;
               e = exp_q.pop_front();
               check("wr_addr", op_wr_cache_addr, e[63:32]);
               check("wr_data", op_wr_cache_data, e[31:0]);
            end
         end
         if (op_wr_cache_done_ctrl) begin
            done_cnt++;
            check("en_done_excl", op_wr_cache_en, 0);
         end
      end
   end

   task automatic do_reset();
      ip_rst = 1'b0;
      ip_byte_valid = 1'b0;
      ip_hold = 1'b0;
      exp_q.delete();
      exp_cnt = 0;
      exp_err = 1'b0;
      repeat (2) @(negedge ip_clk);
      ip_rst = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      @(negedge ip_clk);
      repeat (gap) @(negedge ip_clk);
      ip_byte_data  = b;
      ip_byte_valid = 1'b1;
      t = 0;
      while (!op_byte_ready && t < 50) begin
         @(negedge ip_clk);
         t++;
      end
      if (t >= 50) check("byte_accept", op_byte_ready, 1);
      @(posedge ip_clk);
      #1;
      ip_byte_valid = 1'b0;
      ip_byte_data  = 8'($urandom);
   endtask

   task automatic send_rec(input logic [31:0] a, input logic [31:0] d,
                           input int hold_k, input int max_gap);
      logic [7:0] b[9];
      logic       aligned;
      int         n;
      b[0] = 8'hA5;
      for (int i = 0; i < 4; i++) begin
         b[1+i] = a[8*i +: 8];
         b[5+i] = d[8*i +: 8];
      end
      aligned = (a[1:0] == 2'b00);
      if (aligned) begin
         exp_q.push_back({a, d});
         exp_writes++;
         if (exp_cnt < 65535) exp_cnt++;
      end else begin
         exp_err = 1'b1;
      end
      for (int i = 0; i < 8; i++) send_byte(b[i], $urandom_range(0, max_gap));
      ip_hold = aligned && (hold_k > 0);
      send_byte(b[8], $urandom_range(0, max_gap));
      if (!aligned) begin
         @(negedge ip_clk);
         check("mis_ready_lo", op_byte_ready, 0);
         check("mis_no_en", op_wr_cache_en, 0);
         @(negedge ip_clk);
         check("mis_ready_hi", op_byte_ready, 1);
         check("mis_no_en2", op_wr_cache_en, 0);
      end else begin
         n = (hold_k > 0) ? hold_k : 1;
         for (int k = 0; k < n; k++) begin
            @(negedge ip_clk);
            check("wait_no_en", op_wr_cache_en, 0);
            check("wait_ready_lo", op_byte_ready, 0);
            if (hold_k > 0) begin
               check("hold_addr", op_wr_cache_addr, a);
               check("hold_data", op_wr_cache_data, d);
            end
         end
         ip_hold = 1'b0;
         @(negedge ip_clk);
         check("strobe_en", op_wr_cache_en, 1);
         check("strobe_ready_lo", op_byte_ready, 0);
         @(negedge ip_clk);
         check("post_en_lo", op_wr_cache_en, 0);
         check("post_ready_hi", op_byte_ready, 1);
         check("post_busy_lo", op_busy, 0);
      end
      check("word_count", op_word_count, exp_cnt);
      check("error", op_error, exp_err);
   endtask

   initial begin
      logic [7:0]  jb;
      logic [31:0] ra, rd;
      int          sel;

      // reset values (sampled while reset is asserted)
      #3;
      check("rst_ready", op_byte_ready, 1);
      check("rst_en", op_wr_cache_en, 0);
      check("rst_done", op_wr_cache_done_ctrl, 0);
      check("rst_busy", op_busy, 0);
      check("rst_err", op_error, 0);
      check("rst_cnt", op_word_count, 0);
      check("rst_addr", op_wr_cache_addr, 0);
      check("rst_data", op_wr_cache_data, 0);
      do_reset();

      // A5 04 00 00 00 B7 42 00 00
      send_rec(32'h0000_0004, 32'h0000_42B7, 0, 0);

      // write held for several cycles
      send_rec(32'h0000_0100, 32'hCAFE_F00D, 6, 1);

      // misaligned record followed by a good one
      send_rec(32'h0000_0002, 32'h4433_2211, 0, 0);
      send_rec(32'h0000_0008, 32'h1234_5678, 0, 2);

      // unknown command byte in IDLE
      send_byte(8'h33, 0);
      exp_err = 1'b1;
      @(negedge ip_clk);
      check("junk_busy", op_busy, 0);
      check("junk_ready", op_byte_ready, 1);
      check("junk_err", op_error, exp_err);

      // randomized record mix
      for (int r = 0; r < 40; r++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0) begin
            do jb = 8'($urandom); while (jb == 8'hA5 || jb == 8'h5A);
            send_byte(jb, $urandom_range(0, 3));
            exp_err = 1'b1;
            @(negedge ip_clk);
            check("rnd_junk_busy", op_busy, 0);
            check("rnd_junk_err", op_error, exp_err);
         end else if (sel == 1) begin
            ra = $urandom;
            if (ra[1:0] == 2'b00) ra[0] = 1'b1;
            send_rec(ra, $urandom, 0, 3);
         end else begin
            ra = $urandom;
            ra[1:0] = 2'b00;
            rd = $urandom;
            send_rec(ra, rd, $urandom_range(0, 3), 3);
         end
      end
      check("rnd_en_total", en_cnt, exp_writes);

      // reset in the middle of an address phase
      send_byte(8'hA5, 0);
      send_byte(8'h10, 0);
      send_byte(8'h20, 0);
      send_byte(8'h30, 0);
      @(negedge ip_clk);
      ip_rst = 1'b0;
      #1;
      check("mid_rst_busy", op_busy, 0);
      check("mid_rst_ready", op_byte_ready, 1);
      check("mid_rst_err", op_error, 0);
      check("mid_rst_cnt", op_word_count, 0);
      do_reset();
      send_rec(32'h0000_0020, 32'hA1B2_C3D4, 0, 1);
      check("mid_rst_en_total", en_cnt, exp_writes);

      // full program load: 20 instruction words, 10 data words, then done
      do_reset();
      for (int i = 1; i <= 20; i++) send_rec(32'(4 * i), $urandom, $urandom_range(0, 2), 1);
      for (int j = 0; j < 10; j++) send_rec(32'h4000 + 32'(4 * j), 32'(j + 1), 0, 1);
      check("load_cnt", op_word_count, 30);
      check("load_en_total", en_cnt, exp_writes);

      ip_hold = 1'b1;
      send_byte(8'h5A, 0);
      @(negedge ip_clk);
      check("done_wait", op_wr_cache_done_ctrl, 0);
      check("done_ready_lo", op_byte_ready, 0);
      check("done_busy", op_busy, 1);
      @(negedge ip_clk);
      check("done_strobe", op_wr_cache_done_ctrl, 1);
      @(negedge ip_clk);
      check("done_once", op_wr_cache_done_ctrl, 0);
      check("fin_ready", op_byte_ready, 1);
      check("fin_busy", op_busy, 0);
      ip_hold = 1'b0;

      // traffic after the load is swallowed
      send_byte(8'hA5, 0);
      for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
      send_byte(8'h33, 0);
      repeat (4) @(negedge ip_clk);
      check("fin_cnt", op_word_count, 30);
      check("fin_err", op_error, 0);
      check("fin_en_total", en_cnt, exp_writes);
      check("fin_done_total", done_cnt, 1);
      check("fin_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
